// File: rtl/axi_xbar_nport.sv
// AXI4 1:NSLV crossbar with base/mask decode, independent read/write FSMs and an internal DECERR slave.
// Latency: AR/AW accept -> slave valid 1 cycle; first R beat >= 2 cycles after AR accept; R/W/B beats pass combinationally.
// Backpressure: ready/valid forwarded from the routed slave; one outstanding txn per direction. Macro: AXI_XBAR_SUBWORD_ALIGN_EN.
module axi_xbar_nport #(
    parameter int NSLV   = 3,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter logic [NSLV*ADDR_W-1:0] SLV_BASE = {32'h8000_0000, 32'h0200_0000, 32'h1000_0000},
    parameter logic [NSLV*ADDR_W-1:0] SLV_MASK = {32'hF800_0000, 32'hFFFF_0000, 32'hFFFF_F000}
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     m_awvalid,
    output logic                     m_awready,
    input  logic [ADDR_W-1:0]        m_awaddr,
    input  logic [7:0]               m_awlen,
    input  logic [2:0]               m_awsize,
    input  logic                     m_wvalid,
    output logic                     m_wready,
    input  logic [DATA_W-1:0]        m_wdata,
    input  logic [DATA_W/8-1:0]      m_wstrb,
    input  logic                     m_wlast,
    output logic                     m_bvalid,
    input  logic                     m_bready,
    output logic [1:0]               m_bresp,
    input  logic                     m_arvalid,
    output logic                     m_arready,
    input  logic [ADDR_W-1:0]        m_araddr,
    input  logic [7:0]               m_arlen,
    input  logic [2:0]               m_arsize,
    output logic                     m_rvalid,
    input  logic                     m_rready,
    output logic [DATA_W-1:0]        m_rdata,
    output logic [1:0]               m_rresp,
    output logic                     m_rlast,
    output logic [NSLV-1:0]          s_awvalid,
    input  logic [NSLV-1:0]          s_awready,
    output logic [ADDR_W-1:0]        s_awaddr,
    output logic [7:0]               s_awlen,
    output logic [2:0]               s_awsize,
    output logic [NSLV-1:0]          s_wvalid,
    input  logic [NSLV-1:0]          s_wready,
    output logic [DATA_W-1:0]        s_wdata,
    output logic [DATA_W/8-1:0]      s_wstrb,
    output logic                     s_wlast,
    input  logic [NSLV-1:0]          s_bvalid,
    output logic [NSLV-1:0]          s_bready,
    input  logic [2*NSLV-1:0]        s_bresp,
    output logic [NSLV-1:0]          s_arvalid,
    input  logic [NSLV-1:0]          s_arready,
    output logic [ADDR_W-1:0]        s_araddr,
    output logic [7:0]               s_arlen,
    output logic [2:0]               s_arsize,
    input  logic [NSLV-1:0]          s_rvalid,
    output logic [NSLV-1:0]          s_rready,
    input  logic [NSLV*DATA_W-1:0]   s_rdata,
    input  logic [2*NSLV-1:0]        s_rresp,
    input  logic [NSLV-1:0]          s_rlast,
    output logic [1:0]               access_fault
);
    localparam int RW = $clog2(NSLV + 1);
    localparam logic [RW-1:0] ERR = RW'(NSLV);

    typedef enum logic [1:0] {RS_IDLE, RS_AR, RS_RD} rd_state_t;
    typedef enum logic [1:0] {WS_IDLE, WS_AWW, WS_B} wr_state_t;

    // Descending scan so the lowest matching slot overrides higher ones.
    function automatic logic [RW-1:0] decode(input logic [ADDR_W-1:0] a);
        logic [RW-1:0] r;
        r = ERR;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if ((a & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W])
                r = RW'(i);
        end
        return r;
    endfunction

    rd_state_t         r_rd_state, w_rd_next;
    logic              r_ar_rdy;
    logic [ADDR_W-1:0] r_araddr;
    logic [7:0]        r_arlen, r_rbeat;
    logic [2:0]        r_arsize;
    logic [RW-1:0]     r_ar_route;

    wr_state_t         r_wr_state, w_wr_next;
    logic              r_aw_rdy, r_aw_done, r_w_done;
    logic [ADDR_W-1:0] r_awaddr;
    logic [7:0]        r_awlen;
    logic [2:0]        r_awsize;
    logic [RW-1:0]     r_aw_route;

    logic              w_ar_err, w_aw_err;
    logic              w_sr_arready, w_sr_rvalid, w_sr_rlast;
    logic [DATA_W-1:0] w_sr_rdata, w_rdata_raw;
    logic [1:0]        w_sr_rresp;
    logic              w_sw_awready, w_sw_wready, w_sw_bvalid;
    logic [1:0]        w_sw_bresp;
    logic              w_aw_ok, w_w_ok;

    assign w_ar_err = (r_ar_route == ERR);
    assign w_aw_err = (r_aw_route == ERR);

    always_comb begin
        w_sr_arready = 1'b0;
        w_sr_rvalid  = 1'b0;
        w_sr_rlast   = 1'b0;
        w_sr_rdata   = '0;
        w_sr_rresp   = 2'b00;
        w_sw_awready = 1'b0;
        w_sw_wready  = 1'b0;
        w_sw_bvalid  = 1'b0;
        w_sw_bresp   = 2'b00;
        for (int i = 0; i < NSLV; i++) begin
            if (r_ar_route == RW'(i)) begin
                w_sr_arready = s_arready[i];
                w_sr_rvalid  = s_rvalid[i];
                w_sr_rlast   = s_rlast[i];
                w_sr_rdata   = s_rdata[i*DATA_W +: DATA_W];
                w_sr_rresp   = s_rresp[2*i +: 2];
            end
            if (r_aw_route == RW'(i)) begin
                w_sw_awready = s_awready[i];
                w_sw_wready  = s_wready[i];
                w_sw_bvalid  = s_bvalid[i];
                w_sw_bresp   = s_bresp[2*i +: 2];
            end
        end
    end

    always_comb begin
        w_rd_next   = r_rd_state;
        s_arvalid   = '0;
        s_rready    = '0;
        m_rvalid    = 1'b0;
        w_rdata_raw = '0;
        m_rresp     = 2'b00;
        m_rlast     = 1'b0;
        case (r_rd_state)
            RS_IDLE: if (m_arvalid && r_ar_rdy) w_rd_next = RS_AR;
            RS_AR: begin
                for (int i = 0; i < NSLV; i++)
                    if (r_ar_route == RW'(i)) s_arvalid[i] = 1'b1;
                if (w_ar_err || w_sr_arready) w_rd_next = RS_RD;
            end
            RS_RD: begin
                if (w_ar_err) begin
                    m_rvalid = 1'b1;
                    m_rresp  = 2'b11;
                    m_rlast  = (r_rbeat == r_arlen);
                end else begin
                    for (int i = 0; i < NSLV; i++)
                        if (r_ar_route == RW'(i)) s_rready[i] = m_rready;
                    m_rvalid    = w_sr_rvalid;
                    w_rdata_raw = w_sr_rdata;
                    m_rresp     = w_sr_rresp;
                    m_rlast     = w_sr_rlast;
                end
                if (m_rvalid && m_rready && m_rlast) w_rd_next = RS_IDLE;
            end
            default: w_rd_next = RS_IDLE;
        endcase
    end

`ifdef AXI_XBAR_SUBWORD_ALIGN_EN
    logic [DATA_W-1:0] w_rdata_shift;
    assign w_rdata_shift = w_rdata_raw >> {r_araddr[1:0], 3'b000};
    always_comb begin
        m_rdata = w_rdata_raw;
        if (DATA_W == 32 && !w_ar_err) begin
            case (r_arsize)
                3'd0:    m_rdata = {{(DATA_W-8){1'b0}},  w_rdata_shift[7:0]};
                3'd1:    m_rdata = {{(DATA_W-16){1'b0}}, w_rdata_shift[15:0]};
                3'd2:    m_rdata = w_rdata_shift;
                default: m_rdata = w_rdata_raw;
            endcase
        end
    end
`else
    assign m_rdata = w_rdata_raw;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_state <= RS_IDLE;
            r_ar_rdy   <= 1'b0;
            r_araddr   <= '0;
            r_arlen    <= '0;
            r_arsize   <= '0;
            r_ar_route <= '0;
            r_rbeat    <= '0;
        end else begin
            r_rd_state <= w_rd_next;
            case (r_rd_state)
                RS_IDLE: begin
                    if (m_arvalid && r_ar_rdy) begin
                        r_ar_rdy   <= 1'b0;
                        r_araddr   <= m_araddr;
                        r_arlen    <= m_arlen;
                        r_arsize   <= m_arsize;
                        r_ar_route <= decode(m_araddr);
                        r_rbeat    <= '0;
                    end else begin
                        r_ar_rdy <= 1'b1;
                    end
                end
                RS_RD: if (m_rvalid && m_rready) r_rbeat <= r_rbeat + 8'd1;
                default: ;
            endcase
        end
    end

    // W is forwarded alongside AW so a slave that wants data before address cannot deadlock us.
    always_comb begin
        w_wr_next = r_wr_state;
        s_awvalid = '0;
        s_wvalid  = '0;
        s_bready  = '0;
        m_wready  = 1'b0;
        m_bvalid  = 1'b0;
        m_bresp   = 2'b00;
        w_aw_ok   = 1'b0;
        w_w_ok    = 1'b0;
        case (r_wr_state)
            WS_IDLE: if (m_awvalid && r_aw_rdy) w_wr_next = WS_AWW;
            WS_AWW: begin
                for (int i = 0; i < NSLV; i++) begin
                    if (r_aw_route == RW'(i)) begin
                        s_awvalid[i] = !r_aw_done;
                        s_wvalid[i]  = m_wvalid && !r_w_done;
                    end
                end
                m_wready = !r_w_done && (w_aw_err || w_sw_wready);
                w_aw_ok  = r_aw_done || w_sw_awready;
                w_w_ok   = r_w_done || (m_wvalid && m_wready && m_wlast);
                if (w_aw_ok && w_w_ok) w_wr_next = WS_B;
            end
            WS_B: begin
                if (w_aw_err) begin
                    m_bvalid = 1'b1;
                    m_bresp  = 2'b11;
                end else begin
                    for (int i = 0; i < NSLV; i++)
                        if (r_aw_route == RW'(i)) s_bready[i] = m_bready;
                    m_bvalid = w_sw_bvalid;
                    m_bresp  = w_sw_bresp;
                end
                if (m_bvalid && m_bready) w_wr_next = WS_IDLE;
            end
            default: w_wr_next = WS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_state <= WS_IDLE;
            r_aw_rdy   <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_awaddr   <= '0;
            r_awlen    <= '0;
            r_awsize   <= '0;
            r_aw_route <= '0;
        end else begin
            r_wr_state <= w_wr_next;
            case (r_wr_state)
                WS_IDLE: begin
                    if (m_awvalid && r_aw_rdy) begin
                        r_aw_rdy   <= 1'b0;
                        r_awaddr   <= m_awaddr;
                        r_awlen    <= m_awlen;
                        r_awsize   <= m_awsize;
                        r_aw_route <= decode(m_awaddr);
                        r_aw_done  <= (decode(m_awaddr) == ERR);
                        r_w_done   <= 1'b0;
                    end else begin
                        r_aw_rdy <= 1'b1;
                    end
                end
                WS_AWW: begin
                    if (!r_aw_done && w_sw_awready) r_aw_done <= 1'b1;
                    if (m_wvalid && m_wready && m_wlast) r_w_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign m_arready = r_ar_rdy;
    assign m_awready = r_aw_rdy;
    assign s_araddr  = r_araddr;
    assign s_arlen   = r_arlen;
    assign s_arsize  = r_arsize;
    assign s_awaddr  = r_awaddr;
    assign s_awlen   = r_awlen;
    assign s_awsize  = r_awsize;
    assign s_wdata   = (r_wr_state == WS_AWW) ? m_wdata : '0;
    assign s_wstrb   = (r_wr_state == WS_AWW) ? m_wstrb : '0;
    assign s_wlast   = (r_wr_state == WS_AWW) && m_wlast;

    assign access_fault[0] = m_rvalid && m_rready && (m_rresp != 2'b00);
    assign access_fault[1] = m_bvalid && m_bready && (m_bresp != 2'b00);
endmodule

// File: doc/axi_xbar_nport.md
Name: axi_xbar_nport

Overview:
Parametrised 1-master to NSLV-slave AXI4 crossbar for the NPC memory path. It sits between the IFU/LSU arbiter and the device slaves (UART, CLINT, SRAM/SoC).
- Address decoding is driven by base/mask parameters.
- Routing is registered per transaction, with independent read and write FSMs.
- Full burst pass-through.
- Unmapped addresses are answered by an internal DECERR responder instead of hanging.

Parameters:
NSLV, 3, number of slave ports
ADDR_W, 32, address width
DATA_W, 32, data width
SLV_BASE, {32'h8000_0000, 32'h0200_0000, 32'h1000_0000}, NSLV*ADDR_W flattened bases, slot 0 in LSBs (slot0=UART, slot1=CLINT, slot2=SRAM)
SLV_MASK, {32'hF800_0000, 32'hFFFF_0000, 32'hFFFF_F000}, NSLV*ADDR_W flattened masks

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-low reset
m_awvalid, m_awready, m_awaddr, m_awlen, m_awsize  in/out/in/in/in  1/1/ADDR_W/8/3  master AW
m_wvalid, m_wready, m_wdata, m_wstrb, m_wlast  in/out/in/in/in  1/1/DATA_W/DATA_W/8/1  master W
m_bvalid, m_bready, m_bresp  out/in/out  1/1/2  master B
m_arvalid, m_arready, m_araddr, m_arlen, m_arsize  in/out/in/in/in  1/1/ADDR_W/8/3  master AR
m_rvalid, m_rready, m_rdata, m_rresp, m_rlast  out/in/out/out/out  1/1/DATA_W/2/1  master R
s_awvalid, s_awready  out/in  NSLV each  per-slave AW handshake
s_awaddr, s_awlen, s_awsize  out  ADDR_W/8/3  AW payload shared by all slaves (latched copy)
s_wvalid, s_wready  out/in  NSLV each  per-slave W handshake
s_wdata, s_wstrb, s_wlast  out  DATA_W/DATA_W/8/1  W payload shared
s_bvalid, s_bready, s_bresp  in/out/in  NSLV/NSLV/2*NSLV  per-slave B
s_arvalid, s_arready  out/in  NSLV each  per-slave AR handshake
s_araddr, s_arlen, s_arsize  out  ADDR_W/8/3  AR payload shared (latched copy)
s_rvalid, s_rready, s_rdata, s_rresp, s_rlast  in/out/in/in/in  NSLV/NSLV/NSLV*DATA_W/2*NSLV/NSLV  per-slave R
access_fault  output  2  bit0: 1-cycle pulse on read beat with rresp!=0; bit1: 1-cycle pulse on B with bresp!=0

Behaviour:
- Reset (reset low, async): both FSMs go to IDLE. All outputs 0, including m_arready, m_awready and access_fault. Latched address, len, size, route and beat counter are cleared.
- Decode: slave i hits if (addr & MASK[i]) == BASE[i]. The lowest index wins. No hit selects the internal error slave (route = NSLV).
- Read FSM: IDLE -> AR -> RD -> IDLE.
  - IDLE: the ar_rdy register is set to 1 one cycle after entering IDLE. On m_arvalid & m_arready, latch araddr/arlen/arsize/route, clear ar_rdy, and go to AR.
  - AR: s_arvalid[route]=1 until s_arready[route], then go to RD. For the error route, go to RD the next cycle.
  - RD: mux m_rvalid/m_rdata/m_rresp/m_rlast from s_*[route], and s_rready[route]=m_rready.
  - RD, error route: m_rvalid=1, rdata=0, rresp=2'b11. An 8-bit beat counter advances per handshake, and rlast is asserted when count==arlen.
  - Leave RD on m_rvalid & m_rready & m_rlast.
- Minimum latency AR accept -> first R beat: 2 cycles (error route: exactly 2).
- Write FSM: IDLE -> AWW -> B -> IDLE.
  - IDLE: the aw_rdy behaviour matches ar_rdy.
  - AWW: drive s_awvalid[route] until accepted, tracked by aw_done.
  - AWW: W is forwarded concurrently, never gated on aw_done (deadlock-free): s_wvalid[route]=m_wvalid, m_wready=s_wready[route].
  - AWW, error route: aw_done is immediate and m_wready=1.
  - Go to B when aw_done and a beat with m_wlast has been accepted.
  - B: pass s_bvalid/s_bresp[route], with s_bready[route]=m_bready. Error route: bvalid=1, bresp=2'b11. Exit on handshake.
- Unselected slaves: valid/ready = 0 at all times. One outstanding transaction per direction. Read and write proceed simultaneously and independently, including to the same slave.
- W beats presented while the write FSM is in IDLE are not accepted (m_wready=0).
- Reset mid-burst aborts immediately. No response is generated afterwards.

Optional Feature:
AXI_XBAR_SUBWORD_ALIGN_EN
- Defined, DATA_W=32, non-error route: m_rdata = s_rdata >> (8*araddr_latched[1:0]), zero-masked to 8/16/32 bits for arsize 0/1/2. Other sizes pass raw.
- Undefined: rdata passes raw.

Test Plan:
- AR 0x8000_0010 len=3 size=2, SRAM returns 4 beats -> only s_arvalid[2] asserted; 4 R beats forwarded in order, rlast on beat 4; back to IDLE, m_arready=1 one cycle later.
- AR 0x3000_0000 len=1 -> 2 beats rdata=0 rresp=11, rlast on 2nd; access_fault[0] pulses twice; no s_arvalid asserted.
- AW 0x0200_0004 with W presented before AW accepted; CLINT holds awready low for 3 cycles -> W still completes; B from slot1 forwarded, bresp 00.
- Unmapped AW 0x5000_0000 len=2 -> 3 W beats accepted, B resp=11, access_fault[1] pulses once.
- Concurrent read (UART 0x1000_0005) and write (SRAM), with reset low asserted mid-read -> all outputs 0 immediately; after release both FSMs in IDLE.
- With AXI_XBAR_SUBWORD_ALIGN_EN: lb at 0x1000_0005, slave rdata 0xAABBCCDD -> m_rdata 0x000000CC. Without the macro -> 0xAABBCCDD.
